// File: rtl/mux_a_pipe.sv
// mux_a_pipe: registered N:1 operand-A select for the CPU datapath.
// One of NSRC sources is chosen per accepted transfer and held in a
// two-entry skid buffer (main + skid), so upstream and downstream can
// stall independently. Also flags out-of-range selects (sticky) and
// counts delivered operands.
//
// Handshake: a transfer happens on a side only in a cycle where both
// valid and ready are high at the rising clock edge. A producer holds
// valid and its payload until it sees ready; ready never depends
// combinationally on valid. Here in_ready is decoded from registered
// state only, with no combinational path from out_ready.
module mux_a_pipe #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr,
  output logic [CNTW-1:0]       xfer_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sel_err_q;
  logic             sel_err_d;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic [WIDTH-1:0] muxed;
  logic [31:0]      sel_ext;
  logic             sel_bad;
  logic             accept;
  logic             drain;

  assign sel_ext = {{(32-SELW){1'b0}}, sel};
  assign sel_bad = (sel_ext >= 32'(NSRC));
  assign accept  = in_valid & in_ready_q;
  assign drain   = out_valid_q & out_ready;

  // Source select; an out-of-range index yields zero.
  always_comb begin
    muxed = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_ext == 32'(i)) muxed = src_data[i*WIDTH +: WIDTH];
    end
  end

  // Next values for the sticky error flag (set beats clear) and the counter.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_bad) sel_err_d = 1'b1;
    else if (err_clr)      sel_err_d = 1'b0;
    cnt_d = drain ? cnt_q + 1'b1 : cnt_q;
  end

  // Skid-buffer FSM with registered in_ready/out_valid and data storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= muxed;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_q <= muxed;
          end else if (accept) begin
            skid_q      <= muxed;
            state_q     <= ST_FULL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (drain) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_q      <= skid_q;
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign sel_err   = sel_err_q;
  assign xfer_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_a_pipe.sv
// Bench for mux_a_pipe: three builds (default, NSRC=3, CNTW=2) share one
// stimulus stream and are compared every cycle against a queue model.
module tb_mux_a_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [63:0] src = '0;
  logic [1:0]  sel = '0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        eclr = 1'b0;

  logic        a_in_ready, a_out_valid, a_sel_err;
  logic [15:0] a_out_data;
  logic [7:0]  a_xfer_cnt;
  logic [1:0]  a_dbg;
  logic        b_in_ready, b_out_valid, b_sel_err;
  logic [15:0] b_out_data;
  logic [7:0]  b_xfer_cnt;
  logic [1:0]  b_dbg;
  logic        c_in_ready, c_out_valid, c_sel_err;
  logic [15:0] c_out_data;
  logic [1:0]  c_xfer_cnt;
  logic [1:0]  c_dbg;

  mux_a_pipe #(.WIDTH(16), .NSRC(4), .SELW(2), .CNTW(8)) dut_a (
    .clk(clk), .rst(rst), .src_data(src), .sel(sel), .in_valid(iv),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(ordy), .sel_err(a_sel_err), .err_clr(eclr),
    .xfer_cnt(a_xfer_cnt), .dbg_state(a_dbg));

  mux_a_pipe #(.WIDTH(16), .NSRC(3), .SELW(2), .CNTW(8)) dut_b (
    .clk(clk), .rst(rst), .src_data(src[47:0]), .sel(sel), .in_valid(iv),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(ordy), .sel_err(b_sel_err), .err_clr(eclr),
    .xfer_cnt(b_xfer_cnt), .dbg_state(b_dbg));

  mux_a_pipe #(.WIDTH(16), .NSRC(4), .SELW(2), .CNTW(2)) dut_c (
    .clk(clk), .rst(rst), .src_data(src), .sel(sel), .in_valid(iv),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(ordy), .sel_err(c_sel_err), .err_clr(eclr),
    .xfer_cnt(c_xfer_cnt), .dbg_state(c_dbg));

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];    // expected operands, 4-source build
  logic [15:0] exp3_q[$];   // expected operands, 3-source build
  logic [15:0] last4 = '0;
  logic [15:0] last3 = '0;
  int          cnt = 0;
  logic        err4 = 1'b0;
  logic        err3 = 1'b0;
  bit          armed = 1'b0;

  int checks = 0;
  int passed = 0;

  function automatic logic [15:0] pick(int n);
    if (int'(sel) < n) return src[int'(sel)*16 +: 16];
    return 16'h0000;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: compare outputs with the model, then advance both.
  task automatic cycle();
    bit acc, drn;
    logic [15:0] e4, e3;
    if (armed) begin
      e4 = (exp_q.size() > 0) ? exp_q[0] : last4;
      e3 = (exp3_q.size() > 0) ? exp3_q[0] : last3;
      check("a_in_ready",  32'(a_in_ready),  32'(exp_q.size() < 2));
      check("a_out_valid", 32'(a_out_valid), 32'(exp_q.size() > 0));
      check("a_out_data",  32'(a_out_data),  32'(e4));
      check("a_xfer_cnt",  32'(a_xfer_cnt),  32'(cnt % 256));
      check("a_sel_err",   32'(a_sel_err),   32'(err4));
      check("b_in_ready",  32'(b_in_ready),  32'(exp3_q.size() < 2));
      check("b_out_data",  32'(b_out_data),  32'(e3));
      check("b_sel_err",   32'(b_sel_err),   32'(err3));
      check("c_out_data",  32'(c_out_data),  32'(e4));
      check("c_xfer_cnt",  32'(c_xfer_cnt),  32'(cnt % 4));
    end
    acc = iv && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && ordy;
    e4 = pick(4);
    e3 = pick(3);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp3_q.delete();
      last4 = '0;
      last3 = '0;
      cnt   = 0;
      err4  = 1'b0;
      err3  = 1'b0;
      armed = 1'b1;
    end else begin
      if (drn) begin
        last4 = exp_q.pop_front();
        last3 = exp3_q.pop_front();
        cnt++;
      end
      if (acc) begin
        exp_q.push_back(e4);
        exp3_q.push_back(e3);
      end
      if (acc && int'(sel) >= 3) err3 = 1'b1;
      else if (eclr)             err3 = 1'b0;
      if (eclr) err4 = 1'b0;
    end
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset for two cycles, then idle.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_out_data", 32'(a_out_data), 32'h0);
    check("reset_in_ready", 32'(a_in_ready), 32'h1);

    // Back-to-back transfers, sel=1 then sel=0.
    src  = {16'h5678, 16'h1234, 16'hAF9C, 16'h4AA2};
    ordy = 1'b1;
    iv   = 1'b1;
    sel  = 2'd1;
    cycle();
    check("first_out_AF9C", 32'(a_out_data), 32'hAF9C);
    sel = 2'd0;
    cycle();
    check("second_out_4AA2", 32'(a_out_data), 32'h4AA2);
    iv = 1'b0;
    cycle();
    check("xfer_cnt_two", 32'(a_xfer_cnt), 32'd2);

    // Stall downstream and push three values; the third must wait.
    ordy = 1'b0;
    iv   = 1'b1;
    sel  = 2'd2;
    cycle();
    sel = 2'd3;
    cycle();
    check("in_ready_low_full", 32'(a_in_ready), 32'h0);
    sel = 2'd0;
    src[15:0]  = 16'h9ABC;
    cycle();
    src[47:32] = 16'hDEAD;   // stored entries must not follow this change
    cycle();
    check("stall_hold_1234", 32'(a_out_data), 32'h1234);
    cycle();
    ordy = 1'b1;
    cycle();
    check("release_5678", 32'(a_out_data), 32'h5678);
    cycle();
    check("release_third", 32'(a_out_data), 32'h9ABC);
    iv = 1'b0;
    cycle();
    cycle();

    // Out-of-range select on the 3-source build.
    iv  = 1'b1;
    sel = 2'd3;
    cycle();
    check("bad_sel_zero", 32'(b_out_data), 32'h0);
    check("bad_sel_err",  32'(b_sel_err),  32'h1);
    iv   = 1'b0;
    eclr = 1'b1;
    cycle();
    check("err_clr_clears", 32'(b_sel_err), 32'h0);
    eclr = 1'b0;
    cycle();
    iv   = 1'b1;
    eclr = 1'b1;
    cycle();
    check("set_beats_clear", 32'(b_sel_err), 32'h1);
    iv   = 1'b0;
    eclr = 1'b0;
    cycle();
    cycle();

    // Fill to FULL then reset; stored values must be discarded.
    ordy = 1'b0;
    iv   = 1'b1;
    sel  = 2'd1;
    cycle();
    sel = 2'd2;
    cycle();
    rst  = 1'b1;
    ordy = 1'b1;
    cycle();
    rst = 1'b0;
    iv  = 1'b0;
    check("midrst_out_valid", 32'(a_out_valid), 32'h0);
    check("midrst_in_ready",  32'(a_in_ready),  32'h1);
    cycle();
    cycle();

    // Five drains: the CNTW=2 build wraps 1,2,3,0,1.
    ordy = 1'b1;
    iv   = 1'b1;
    repeat (5) begin
      sel = 2'($urandom_range(0, 3));
      src = {$urandom, $urandom};
      cycle();
    end
    iv = 1'b0;
    cycle();
    check("wrap_cnt_c", 32'(c_xfer_cnt), 32'd1);
    cycle();

    // Random traffic.
    repeat (400) begin
      src  = {$urandom, $urandom};
      sel  = 2'($urandom_range(0, 3));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      eclr = ($urandom_range(0, 7) == 0);
      cycle();
    end
    iv   = 1'b0;
    ordy = 1'b1;
    eclr = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
